transmisor_hamming: RTL

Transmit side of the SECDED link: accepts a 4-bit data nibble over a valid/ready handshake and encodes it into an 8-bit extended Hamming(7,4) codeword. It then shifts the codeword out serially in a start/data/stop frame. An optional error mask corrupts the serial frame so the receiving correction block can be exercised with single and double errors. The block sits upstream of the serial receiver that feeds the syndrome/correction stage.

---
 rtl/transmisor_hamming.sv | 132 +++++++++++++
 1 files changed

// File: rtl/transmisor_hamming.sv
// SECDED link transmitter: encodes a nibble into an extended Hamming(7,4)
// codeword and sends it as a start/8 data/stop serial frame, LSB first.
`timescale 1ns/1ps
module transmisor_hamming #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [3:0] dato,
    input  logic       valido,
    input  logic [7:0] mascara_error,
    output logic       listo,
    output logic       ocupado,
    output logic       tx,
    output logic [7:0] palabra_codificada,
    output logic       fin
);

    typedef enum logic [1:0] {
        REPOSO,
        INICIO,
        DATOS,
        PARADA
    } estado_t;

    localparam logic [7:0] ULTIMO = 8'(CICLOS_POR_BIT - 1);

    estado_t    estado, estado_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] sh, sh_n;
    logic [7:0] palabra_n;
    logic [7:0] codigo;
    logic       tx_n, fin_n, ultimo;

    always_comb begin
        codigo    = 8'h00;
        codigo[3] = dato[0];
        codigo[5] = dato[1];
        codigo[6] = dato[2];
        codigo[7] = dato[3];
        codigo[1] = dato[0] ^ dato[1] ^ dato[3];
        codigo[2] = dato[0] ^ dato[2] ^ dato[3];
        codigo[4] = dato[1] ^ dato[2] ^ dato[3];
        codigo[0] = ^codigo[7:1];
    end

    assign ultimo = (cnt == ULTIMO);

    always_comb begin
        estado_n  = estado;
        cnt_n     = cnt;
        bit_n     = bit_cnt;
        sh_n      = sh;
        tx_n      = tx;
        fin_n     = 1'b0;
        palabra_n = palabra_codificada;
        unique case (estado)
            REPOSO: begin
                tx_n = 1'b1;
                if (valido) begin
                    palabra_n = codigo;
                    sh_n      = codigo ^ mascara_error;
                    cnt_n     = 8'd0;
                    bit_n     = 3'd0;
                    tx_n      = 1'b0;
                    estado_n  = INICIO;
                end
            end
            INICIO: begin
                if (ultimo) begin
                    cnt_n    = 8'd0;
                    tx_n     = sh[0];
                    estado_n = DATOS;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DATOS: begin
                if (ultimo) begin
                    cnt_n = 8'd0;
                    bit_n = bit_cnt + 3'd1;
                    sh_n  = {1'b0, sh[7:1]};
                    // Bit counter wrapping past 7 closes the data field
                    if (bit_cnt == 3'd7) begin
                        tx_n     = 1'b1;
                        estado_n = PARADA;
                    end else begin
                        tx_n = sh[1];
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PARADA: begin
                if (ultimo) begin
                    cnt_n    = 8'd0;
                    fin_n    = 1'b1;
                    estado_n = REPOSO;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: estado_n = REPOSO;
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado             <= REPOSO;
            cnt                <= 8'd0;
            bit_cnt            <= 3'd0;
            sh                 <= 8'h00;
            tx                 <= 1'b1;
            fin                <= 1'b0;
            palabra_codificada <= 8'h00;
            listo              <= 1'b1;
            ocupado            <= 1'b0;
        end else begin
            estado             <= estado_n;
            cnt                <= cnt_n;
            bit_cnt            <= bit_n;
            sh                 <= sh_n;
            tx                 <= tx_n;
            fin                <= fin_n;
            palabra_codificada <= palabra_n;
            listo              <= (estado_n == REPOSO);
            ocupado            <= (estado_n != REPOSO);
        end
    end

endmodule
